// File: rtl/rib_rr_xbar.sv
// N-master / M-slave bus crossbar with a registered fixed-priority or round-robin arbiter.
// Each grant lasts one transaction and ends on slave ready, decode error, timeout or master abandon.
module rib_rr_xbar #(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255,
  parameter logic [NUM_M-1:0] HOLD_MASK = 4'b1101
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_req_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr_i,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata_i,
  output logic [NUM_M*DATA_W-1:0]    m_rdata_o,
  output logic [NUM_M-1:0]           m_ready_o,
  output logic [NUM_M-1:0]           m_err_o,
  output logic [NUM_S-1:0]           s_req_o,
  output logic [NUM_S-1:0]           s_we_o,
  output logic [NUM_S*ADDR_W-1:0]    s_addr_o,
  output logic [NUM_S*DATA_W-1:0]    s_wdata_o,
  input  logic [NUM_S*DATA_W-1:0]    s_rdata_i,
  input  logic [NUM_S-1:0]           s_ready_i,
  output logic [$clog2(NUM_M)-1:0]   gnt_idx_o,
  output logic                       busy_o,
  output logic                       hold_flag_o
);

  localparam int GW  = $clog2(NUM_M);
  localparam int TCW = $clog2(TIMEOUT + 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     gnt_idx, rr_ptr, winner, base, cand;
  logic              found;
  logic [TCW-1:0]    tcnt;

  logic              g_req, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [SEL_W-1:0]  sel;
  logic              mapped, slave_rdy;
  logic [DATA_W-1:0] slave_rdata;
  logic              active, route, ok, timed_out, bad_addr, done, abandon;

  // Search starts at the round-robin pointer, or at master 0 in fixed-priority mode.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    base   = (RR_EN != 0) ? rr_ptr : '0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = GW'((int'(base) + i) % NUM_M);
      if (!found && m_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    g_req   = 1'b0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_idx == GW'(k)) begin
        g_req   = m_req_i[k];
        g_we    = m_we_i[k];
        g_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
        g_wdata = m_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel    = g_addr[ADDR_W-1 -: SEL_W];
  assign mapped = (int'(sel) < NUM_S);

  always_comb begin
    slave_rdy   = 1'b0;
    slave_rdata = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (int'(sel) == s) begin
        slave_rdy   = s_ready_i[s];
        slave_rdata = s_rdata_i[s*DATA_W +: DATA_W];
      end
    end
  end

  // A ready arriving in the timeout cycle takes precedence over the timeout error.
  assign active    = (state == BUSY) && rst;
  assign route     = active && g_req && mapped;
  assign ok        = route && slave_rdy;
  assign timed_out = route && !slave_rdy && (TIMEOUT != 0) && (int'(tcnt) == TIMEOUT);
  assign bad_addr  = active && g_req && !mapped;
  assign done      = ok || timed_out || bad_addr;
  assign abandon   = active && !g_req;

  always_comb begin
    m_ready_o = '0;
    m_err_o   = '0;
    m_rdata_o = '0;
    s_req_o   = '0;
    s_we_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (done && (gnt_idx == GW'(k))) begin
        m_ready_o[k] = 1'b1;
        m_err_o[k]   = !ok;
        if (ok) m_rdata_o[k*DATA_W +: DATA_W] = slave_rdata;
      end
    end
    for (int s = 0; s < NUM_S; s++) begin
      if (route && (int'(sel) == s)) begin
        s_req_o[s]                    = 1'b1;
        s_we_o[s]                     = g_we;
        s_addr_o[s*ADDR_W +: ADDR_W]  = g_addr;
        s_wdata_o[s*DATA_W +: DATA_W] = g_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|m_req_i) state_nxt = BUSY;
      BUSY:    if (done || abandon) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The wait counter is held at zero in IDLE, so every transaction starts counting from 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      tcnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (|m_req_i) gnt_idx <= winner;
        tcnt <= '0;
      end else if (!slave_rdy) begin
        tcnt <= tcnt + 1'b1;
      end
      if (done) rr_ptr <= GW'((int'(gnt_idx) + 1) % NUM_M);
    end
  end

  assign gnt_idx_o   = gnt_idx;
  assign busy_o      = (state == BUSY);
  assign hold_flag_o = |(m_req_i & HOLD_MASK);

endmodule

// File: tb/tb_rib_rr_xbar.sv
// Bench for rib_rr_xbar: a round-robin/TIMEOUT=4 instance and a fixed-priority/TIMEOUT=255
// instance share stimulus and are compared every cycle against a transaction-level model.
module tb_rib_rr_xbar;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req, m_we;
  logic [127:0] m_addr, m_wdata;
  logic [255:0] s_rdata;
  logic [7:0]   s_ready;

  logic [127:0] a_m_rdata, b_m_rdata;
  logic [3:0]   a_m_ready, b_m_ready, a_m_err, b_m_err;
  logic [7:0]   a_s_req, b_s_req, a_s_we, b_s_we;
  logic [255:0] a_s_addr, b_s_addr, a_s_wdata, b_s_wdata;
  logic [1:0]   a_gnt, b_gnt;
  logic         a_busy, b_busy, a_hold, b_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rib_rr_xbar #(.RR_EN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_rdata_o(a_m_rdata), .m_ready_o(a_m_ready), .m_err_o(a_m_err),
    .s_req_o(a_s_req), .s_we_o(a_s_we), .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata),
    .s_rdata_i(s_rdata), .s_ready_i(s_ready), .gnt_idx_o(a_gnt), .busy_o(a_busy),
    .hold_flag_o(a_hold));

  rib_rr_xbar #(.RR_EN(0), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_rdata_o(b_m_rdata), .m_ready_o(b_m_ready), .m_err_o(b_m_err),
    .s_req_o(b_s_req), .s_we_o(b_s_we), .s_addr_o(b_s_addr), .s_wdata_o(b_s_wdata),
    .s_rdata_i(s_rdata), .s_ready_i(s_ready), .gnt_idx_o(b_gnt), .busy_o(b_busy),
    .hold_flag_o(b_hold));

  typedef struct {
    logic [127:0] rdata;
    logic [3:0]   ready, err;
    logic [7:0]   sreq, swe;
    logic [255:0] saddr, swdata;
    logic [1:0]   gnt;
    logic         busy, hold;
  } out_t;

  // Model state per instance: is a transaction open, who owns it, cycles waited, RR start point.
  int mdl_rr[2]  = '{1, 0};
  int mdl_tmo[2] = '{4, 255};
  bit mdl_open[2]  = '{0, 0};
  int mdl_owner[2] = '{0, 0};
  int mdl_wait[2]  = '{0, 0};
  int mdl_ptr[2]   = '{0, 0};
  bit nxt_open[2];
  int nxt_owner[2], nxt_wait[2], nxt_ptr[2];

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic modelEval(input int u, output out_t e);
    int g, sel, first, pick;
    bit fin;
    g = mdl_owner[u];
    e.rdata = '0; e.ready = '0; e.err = '0; e.sreq = '0; e.swe = '0;
    e.saddr = '0; e.swdata = '0;
    e.gnt  = 2'(g);
    e.busy = mdl_open[u];
    e.hold = m_req[0] | m_req[2] | m_req[3];
    nxt_open[u] = mdl_open[u]; nxt_owner[u] = mdl_owner[u];
    nxt_wait[u] = mdl_wait[u]; nxt_ptr[u] = mdl_ptr[u];
    if (!rst) begin
      nxt_open[u] = 0; nxt_owner[u] = 0; nxt_wait[u] = 0; nxt_ptr[u] = 0;
    end else if (!mdl_open[u]) begin
      if (m_req != 4'b0) begin
        first = (mdl_rr[u] != 0) ? mdl_ptr[u] : 0;
        pick  = -1;
        for (int i = 0; i < 4; i++)
          if (pick < 0 && ((m_req >> ((first + i) % 4)) & 4'b1) != 4'b0) pick = (first + i) % 4;
        nxt_owner[u] = pick; nxt_open[u] = 1; nxt_wait[u] = 0;
      end
    end else if (((m_req >> g) & 4'b1) == 4'b0) begin
      nxt_open[u] = 0;
    end else begin
      sel = int'(m_addr[g*32+28 +: 4]);
      fin = 0;
      if (sel >= 8) begin
        e.ready = 4'b0001 << g; e.err = 4'b0001 << g; fin = 1;
      end else begin
        e.sreq   = 8'b1 << sel;
        e.swe    = (((m_we >> g) & 4'b1) != 4'b0) ? (8'b1 << sel) : 8'b0;
        e.saddr  = 256'(m_addr[g*32 +: 32]) << (sel*32);
        e.swdata = 256'(m_wdata[g*32 +: 32]) << (sel*32);
        if (((s_ready >> sel) & 8'b1) != 8'b0) begin
          e.ready = 4'b0001 << g;
          e.rdata = 128'(s_rdata[sel*32 +: 32]) << (g*32);
          fin = 1;
        end else if (mdl_tmo[u] != 0 && mdl_wait[u] == mdl_tmo[u]) begin
          e.ready = 4'b0001 << g; e.err = 4'b0001 << g; fin = 1;
        end else begin
          nxt_wait[u] = mdl_wait[u] + 1;
        end
      end
      if (fin) begin nxt_open[u] = 0; nxt_ptr[u] = (g + 1) % 4; end
    end
  endtask

  task automatic compareOut(input string p, input out_t o, input out_t e);
    checkOutput({p, ".m_rdata"}, 256'(o.rdata), 256'(e.rdata));
    checkOutput({p, ".m_ready"}, 256'(o.ready), 256'(e.ready));
    checkOutput({p, ".m_err"},   256'(o.err),   256'(e.err));
    checkOutput({p, ".s_req"},   256'(o.sreq),  256'(e.sreq));
    checkOutput({p, ".s_we"},    256'(o.swe),   256'(e.swe));
    checkOutput({p, ".s_addr"},  o.saddr,       e.saddr);
    checkOutput({p, ".s_wdata"}, o.swdata,      e.swdata);
    checkOutput({p, ".gnt_idx"}, 256'(o.gnt),   256'(e.gnt));
    checkOutput({p, ".busy"},    256'(o.busy),  256'(e.busy));
    checkOutput({p, ".hold"},    256'(o.hold),  256'(e.hold));
  endtask

  // Called just after inputs change on the falling edge; compares both instances to the model.
  task automatic applyStimulus();
    out_t ea, eb, oa, ob;
    #1;
    modelEval(0, ea);
    modelEval(1, eb);
    oa.rdata = a_m_rdata; oa.ready = a_m_ready; oa.err = a_m_err; oa.sreq = a_s_req;
    oa.swe = a_s_we; oa.saddr = a_s_addr; oa.swdata = a_s_wdata; oa.gnt = a_gnt;
    oa.busy = a_busy; oa.hold = a_hold;
    ob.rdata = b_m_rdata; ob.ready = b_m_ready; ob.err = b_m_err; ob.sreq = b_s_req;
    ob.swe = b_s_we; ob.saddr = b_s_addr; ob.swdata = b_s_wdata; ob.gnt = b_gnt;
    ob.busy = b_busy; ob.hold = b_hold;
    compareOut("A", oa, ea);
    compareOut("B", ob, eb);
  endtask

  task automatic advanceClock();
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      mdl_open[u] = nxt_open[u]; mdl_owner[u] = nxt_owner[u];
      mdl_wait[u] = nxt_wait[u]; mdl_ptr[u] = nxt_ptr[u];
    end
    @(negedge clk);
  endtask

  task automatic setMaster(input int k, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
    m_req[k] = req;
    m_we[k]  = we;
    m_addr[k*32 +: 32]  = addr;
    m_wdata[k*32 +: 32] = wd;
  endtask

  task automatic idleCycles(input int n, input logic r);
    m_req = '0; rst = r; s_ready = 8'hFF;
    for (int i = 0; i < n; i++) begin applyStimulus(); advanceClock(); end
    rst = 1'b1;
  endtask

  int order[$];
  int when[$];
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int sreq_cnt, rdy_cnt, err_cnt, err_at;
  logic [31:0] seen_rdata;
  logic seen_err;
  logic [7:0] sreq_or;

  initial begin
    rst = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; s_ready = 8'hFF;
    for (int s = 0; s < 8; s++) s_rdata[s*32 +: 32] = 32'hA000_0000 + 32'(s);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state and hold flag while held in reset
    m_req = 4'b0001; applyStimulus();
    checkOutput("reset_busy", 256'({a_busy, b_busy}), 256'(0));
    checkOutput("reset_ready", 256'({a_m_ready, b_m_ready}), 256'(0));
    checkOutput("hold_m0", 256'(a_hold), 256'(1));
    advanceClock();
    m_req = 4'b0010; applyStimulus();
    checkOutput("hold_m1", 256'(a_hold), 256'(0));
    advanceClock();
    idleCycles(1, 1'b1);

    // Fixed priority: m0 and m2 together on zero-wait slave 0
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        setMaster(0, 1, 0, 32'h0000_0000, 32'h0);
        setMaster(2, 1, 1, 32'h0000_0040, 32'h1234_5678);
      end
      if (i == 2) m_req[0] = 1'b0;
      if (i == 4) m_req[2] = 1'b0;
      applyStimulus();
      if (i == 1) begin
        checkOutput("fp_gnt_m0", 256'(b_gnt), 256'(0));
        checkOutput("fp_ready_m0", 256'(b_m_ready), 256'(4'b0001));
      end
      if (i == 3) begin
        checkOutput("fp_gnt_m2", 256'(b_gnt), 256'(2));
        checkOutput("fp_ready_m2", 256'(b_m_ready), 256'(4'b0100));
      end
      advanceClock();
    end

    // Round robin: all four masters request continuously
    idleCycles(1, 1'b0);
    for (int k = 0; k < 4; k++) setMaster(k, 1, 0, 32'h1000_0000 + 32'(k*4), 32'h0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      for (int k = 0; k < 4; k++)
        if (a_m_ready[k]) begin order.push_back(k); when.push_back(i); end
      advanceClock();
    end
    checkOutput("rr_count", 256'(order.size()), 256'(5));
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checkOutput("rr_order", 256'(order[i]), 256'(rr_exp[i]));
      if (i > 0) checkOutput("rr_spacing", 256'(when[i] - when[i-1]), 256'(2));
    end
    idleCycles(2, 1'b1);

    // Wait-state slave 3, ready after 5 wait cycles
    sreq_cnt = 0; rdy_cnt = 0; seen_rdata = '0; seen_err = 1'b1;
    s_rdata[3*32 +: 32] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) setMaster(1, 1, 0, 32'h3000_0010, 32'h0);
      if (i == 7) m_req[1] = 1'b0;
      s_ready = 8'hFF; s_ready[3] = (i == 6);
      applyStimulus();
      if (b_s_req[3]) sreq_cnt++;
      if (b_m_ready[1]) begin rdy_cnt++; seen_rdata = b_m_rdata[63:32]; seen_err = b_m_err[1]; end
      advanceClock();
    end
    checkOutput("ws_sreq_cycles", 256'(sreq_cnt), 256'(6));
    checkOutput("ws_ready_pulses", 256'(rdy_cnt), 256'(1));
    checkOutput("ws_rdata", 256'(seen_rdata), 256'(32'hDEAD_BEEF));
    checkOutput("ws_err", 256'(seen_err), 256'(0));
    idleCycles(2, 1'b1);

    // Unmapped address
    sreq_or = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) setMaster(0, 1, 0, 32'h9000_0000, 32'h0);
      if (i == 2) m_req[0] = 1'b0;
      applyStimulus();
      sreq_or = sreq_or | a_s_req | b_s_req;
      if (i == 1) begin
        checkOutput("unmap_ready", 256'({a_m_ready, b_m_ready}), 256'(8'h11));
        checkOutput("unmap_err", 256'({a_m_err, b_m_err}), 256'(8'h11));
      end
      advanceClock();
    end
    checkOutput("unmap_no_sreq", 256'(sreq_or), 256'(0));
    idleCycles(2, 1'b1);

    // Timeout on instance A (TIMEOUT=4), then ready exactly at count 4
    for (int pass = 0; pass < 2; pass++) begin
      err_cnt = 0; err_at = -1;
      for (int i = 0; i < 8; i++) begin
        if (i == 0) setMaster(2, 1, 1, 32'h6000_0100, 32'hCAFE_0000 + 32'(pass));
        if (i == 6) m_req[2] = 1'b0;
        s_ready = 8'hFF; s_ready[6] = (pass == 1) && (i == 5);
        applyStimulus();
        if (a_m_err[2]) begin err_cnt++; err_at = i; end
        if (i == 4) checkOutput("tmo_sreq_held", 256'(a_s_req[6]), 256'(1));
        if (i == 5) checkOutput("tmo_ready", 256'(a_m_ready), 256'(4'b0100));
        if (i == 6) checkOutput("tmo_sreq_dropped", 256'({a_s_req, a_busy}), 256'(0));
        advanceClock();
      end
      if (pass == 0) begin
        checkOutput("tmo_err_pulses", 256'(err_cnt), 256'(1));
        checkOutput("tmo_err_cycle", 256'(err_at), 256'(5));
      end else begin
        checkOutput("tmo_ready_wins", 256'(err_cnt), 256'(0));
      end
      idleCycles(2, 1'b1);
    end

    // Reset in the middle of a transaction
    for (int i = 0; i < 5; i++) begin
      if (i == 0) setMaster(1, 1, 0, 32'h3000_0000, 32'h0);
      s_ready = 8'hF7;
      rst = (i != 2);
      if (i == 3) m_req = '0;
      applyStimulus();
      if (i == 3) begin
        checkOutput("rst_busy", 256'({a_busy, b_busy}), 256'(0));
        checkOutput("rst_gnt", 256'({a_gnt, b_gnt}), 256'(0));
        checkOutput("rst_outputs", 256'({a_m_ready, a_m_err, a_s_req, b_m_ready, b_s_req}), 256'(0));
      end
      advanceClock();
    end
    rst = 1'b1;

    // Abandon keeps the round-robin pointer where it was
    idleCycles(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin s_ready = 8'h00; setMaster(1, 1, 0, 32'h3000_0020, 32'h0); end
      if (i == 2) m_req = '0;
      if (i == 4) begin
        s_ready = 8'hFF;
        for (int k = 0; k < 4; k++) setMaster(k, 1, 0, 32'h1000_0000, 32'h0);
      end
      if (i == 6) m_req = '0;
      applyStimulus();
      if (i == 2) checkOutput("abandon_quiet", 256'({a_s_req, a_m_ready, b_s_req, b_m_ready}), 256'(0));
      if (i == 3) checkOutput("abandon_idle", 256'({a_busy, b_busy}), 256'(0));
      if (i == 5) begin
        checkOutput("abandon_ptr_gnt", 256'(a_gnt), 256'(0));
        checkOutput("abandon_ptr_ready", 256'(a_m_ready), 256'(4'b0001));
      end
      advanceClock();
    end

    // Randomised traffic with occasional resets
    idleCycles(1, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (m_req[k]) begin
          if ($urandom_range(0, 7) == 0) m_req[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          setMaster(k, 1, 1'($urandom_range(0, 1)),
                    {4'($urandom_range(0, 9)), 28'($urandom)}, $urandom);
        end
      end
      for (int s = 0; s < 8; s++) begin
        s_ready[s] = (s == 6) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        s_rdata[s*32 +: 32] = $urandom;
      end
      rst = ($urandom_range(0, 99) != 0);
      applyStimulus();
      advanceClock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
